id_pipe_ctrl: RTL and testbench
===============================

ID_PIPE_CTRL -- requirements
Module: id_pipe_ctrl

Interface
REQ-001 Parameter EXE_CMD_W, default 4, width of exe_cmd; values above 4 zero-extend the 4-bit command.
REQ-002 Parameter BR_SHADOW, default 1, legal 0..3, number of instructions squashed after an accepted branch.
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream instruction fields valid.
REQ-007 in_ready  output  1  block accepts the instruction this cycle.
REQ-008 opcode  input  4  data-processing opcode.
REQ-009 mode  input  2  instruction class: 00 RT, 01 MT, 10 BT, 11 reserved.
REQ-010 s_in  input  1  S bit (RT) or L bit (MT).
REQ-011 flush  input  1  discard held and incoming instruction, cancel shadow.
REQ-012 out_valid  output  1  registered control word valid.
REQ-013 out_ready  input  1  downstream EXE stage takes the control word.
REQ-014 wb_en, mem_r_en, mem_w_en, b, s_out, illegal  output  1 each  registered control bits.
REQ-015 exe_cmd  output  EXE_CMD_W  registered ALU command.
REQ-016 cnt_dec, cnt_sq  output  CNT_W each  decoded / squashed counts (only with ID_PERF_CNT_EN).

Function
REQ-017 in_ready SHALL equal (!out_valid | out_ready) & !flush, combinationally.
REQ-018 Accept SHALL occur when in_valid & in_ready; the decoded word is registered, giving 1-cycle latency.
REQ-019 The output register SHALL hold all outputs stable while out_valid & !out_ready.
REQ-020 When out_ready & out_valid and no accept occurs in the same cycle, out_valid SHALL clear.
REQ-021 RT decode (opcode->exe_cmd, wb_en): MOV 1101->0001,1; MVN 1111->1001,1; ADD 0100->0010,1; ADC 0101->0011,1; SUB 0010->0100,1; SBC 0110->0101,1; AND 0000->0110,1; ORR 1100->0111,1; EOR 0001->1000,1; CMP 1010->0100,0; TST 1000->0110,0.
REQ-022 RT: s_out SHALL equal s_in; an undefined opcode SHALL give all controls 0 and illegal=1.
REQ-023 MT: exe_cmd=0010; s_in=1 (LDR) SHALL give mem_r_en=1, wb_en=1; s_in=0 (STR) SHALL give mem_w_en=1, wb_en=0; s_out=0.
REQ-024 BT: b=1, all other controls 0; mode 11: all controls 0, illegal=1.
REQ-025 Illegal words SHALL still be forwarded with out_valid=1.
REQ-026 Shadow FSM: IDLE (shadow_cnt=0) and SHADOW (shadow_cnt>0); an accepted non-squashed branch with BR_SHADOW>0 SHALL load shadow_cnt=BR_SHADOW and enter SHADOW.
REQ-027 In SHADOW, each accepted instruction SHALL be consumed and not loaded (out_valid unaffected), shadow_cnt decrements, return to IDLE at 0; a branch in shadow is squashed and does not reload.
REQ-028 flush SHALL, on the next edge, clear out_valid and shadow_cnt; flush has priority over accept and out_ready.
REQ-029 Accept and downstream take in the same cycle SHALL overwrite the register with out_valid kept 1.

Reset
REQ-030 While rst_n=0: out_valid, all control bits, exe_cmd, shadow_cnt, cnt_dec, cnt_sq SHALL be 0, state IDLE; reset mid-shadow discards the shadow.

Configuration
REQ-031 With ID_PERF_CNT_EN defined, cnt_dec SHALL increment per non-squashed accept and cnt_sq per squashed accept, both wrapping modulo 2^CNT_W and unaffected by flush.
REQ-032 Without ID_PERF_CNT_EN, cnt_dec and cnt_sq ports and logic SHALL be absent.

Structure
REQ-033 Package id_pkg SHALL hold mode codes, opcode codes, 4-bit exe_cmd codes and the control-word struct.
REQ-034 Pure decode SHALL live in combinational sub-module id_decode_lut; id_pipe_ctrl adds handshake, shadow FSM and counters.

Verification
REQ-035 ADD (mode 00, opcode 0100, s_in 1), out_ready=1 -> next cycle out_valid=1, exe_cmd=0010, wb_en=1, s_out=1.
REQ-036 LDR then STR back-to-back with out_ready=0 for 3 cycles -> LDR word held, in_ready=0; STR appears one cycle after out_ready rises.
REQ-037 BR_SHADOW=2: B, MOV, SUB, AND -> only B and AND reach output; cnt_sq=2, cnt_dec=2.
REQ-038 flush asserted with in_valid=1 while out_valid=1 and in SHADOW -> next cycle out_valid=0, shadow_cnt=0, instruction dropped.
REQ-039 mode 11 and RT opcode 0011 -> out_valid=1, illegal=1, all other controls 0.
REQ-040 rst_n low mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: instruction class codes, RT opcodes,
// 4-bit ALU command codes and the registered control-word layout.
// No logic; imported by id_decode_lut and id_pipe_ctrl.
package id_pkg;

  // Instruction class carried on the 2-bit mode field.
  typedef enum logic [1:0] {
    MODE_RT  = 2'b00,  // register / data-processing
    MODE_MT  = 2'b01,  // memory transfer (LDR/STR)
    MODE_BT  = 2'b10,  // branch
    MODE_RSV = 2'b11   // reserved, decodes as illegal
  } mode_e;

  // Data-processing opcodes recognised in the RT class.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands understood by the EXE stage.
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // Control word handed to EXE.
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s_out;
    logic       illegal;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Undecodable instruction: every control off, only the illegal flag raised.
  function automatic ctrl_t ctrl_illegal();
    ctrl_t c;
    c         = CTRL_NONE;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/id_decode_lut.sv
// Purpose: pure combinational decode of {mode, opcode, s_in} into a control word.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides when the word is captured.
// Ports: mode/opcode/s_in instruction fields in, ctrl decoded control word out.
module id_decode_lut
  import id_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_in,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (mode)
      MODE_RT: begin
        // Defaults for a writing data-processing op; compares and unknowns override.
        ctrl.wb_en = 1'b1;
        ctrl.s_out = s_in;
        case (opcode)
          OP_MOV:  ctrl.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl.exe_cmd = EXE_SBC;
          OP_AND:  ctrl.exe_cmd = EXE_AND;
          OP_ORR:  ctrl.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl.exe_cmd = EXE_EOR;
          // CMP/TST only set flags, so no register write-back.
          OP_CMP: begin
            ctrl.exe_cmd = EXE_SUB;
            ctrl.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd = EXE_AND;
            ctrl.wb_en   = 1'b0;
          end
          default: ctrl = ctrl_illegal();
        endcase
      end
      MODE_MT: begin
        // Address generation is always an add; s_in is the L bit.
        ctrl.exe_cmd = EXE_ADD;
        if (s_in) begin
          ctrl.mem_r_en = 1'b1;
          ctrl.wb_en    = 1'b1;
        end else begin
          ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BT: ctrl.b = 1'b1;
      default: ctrl = ctrl_illegal();
    endcase
  end

endmodule

// File: rtl/id_pipe_ctrl.sv
// Purpose: ID-stage control register: decodes, squashes branch-shadow slots, forwards to EXE.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: holds the word while out_valid & !out_ready; in_ready drops; flush overrides all.
// Ports: clk/rst_n; in_valid/in_ready + opcode/mode/s_in/flush upstream; out_valid/out_ready +
//        wb_en/mem_r_en/mem_w_en/b/s_out/illegal/exe_cmd downstream.
// Optional macro ID_PERF_CNT_EN adds cnt_dec / cnt_sq accept counters (ports absent otherwise).
module id_pipe_ctrl
  import id_pkg::*;
#(
  parameter int EXE_CMD_W = 4,
  parameter int BR_SHADOW = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [1:0]           mode,
  input  logic                 s_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 b,
  output logic                 s_out,
  output logic                 illegal,
  output logic [EXE_CMD_W-1:0] exe_cmd
`ifdef ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cnt_dec,
  output logic [CNT_W-1:0]     cnt_sq
`endif
);

  if (BR_SHADOW < 0 || BR_SHADOW > 3 || EXE_CMD_W < 4 || CNT_W < 1) begin : g_bad_param
    $error("id_pipe_ctrl: parameter out of range");
  end

  localparam logic [1:0] SHADOW_LOAD = 2'(BR_SHADOW);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SHADOW = 1'b1;

  ctrl_t      dec_ctrl;
  ctrl_t      ctrl_q, ctrl_d;
  logic       out_valid_q, out_valid_d;
  logic [0:0] state_q, state_d;
  logic [1:0] shadow_cnt_q, shadow_cnt_d;
  logic       accept, squash, load;

  id_decode_lut u_decode (
    .mode   (mode),
    .opcode (opcode),
    .s_in   (s_in),
    .ctrl   (dec_ctrl)
  );

  // flush gates in_ready, so an accept can never coincide with a flush.
  assign in_ready = (!out_valid_q | out_ready) & !flush;
  assign accept   = in_valid & in_ready;
  // Slots behind an accepted branch are consumed from upstream but never reach EXE.
  assign squash   = accept & (state_q == ST_SHADOW);
  assign load     = accept & !squash;

  // Output register: flush > load > downstream take > hold.
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Branch-shadow FSM; shadow_cnt_q is non-zero exactly when state_q is ST_SHADOW.
  always_comb begin
    state_d      = state_q;
    shadow_cnt_d = shadow_cnt_q;
    if (flush) begin
      state_d      = ST_IDLE;
      shadow_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load && dec_ctrl.b && (SHADOW_LOAD != 2'd0)) begin
            state_d      = ST_SHADOW;
            shadow_cnt_d = SHADOW_LOAD;
          end
        end
        ST_SHADOW: begin
          // A squashed branch does not re-arm the shadow.
          if (squash) begin
            shadow_cnt_d = shadow_cnt_q - 2'd1;
            if (shadow_cnt_q == 2'd1) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d      = ST_IDLE;
          shadow_cnt_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      ctrl_q       <= CTRL_NONE;
      state_q      <= ST_IDLE;
      shadow_cnt_q <= 2'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      ctrl_q       <= ctrl_d;
      state_q      <= state_d;
      shadow_cnt_q <= shadow_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wb_en     = ctrl_q.wb_en;
  assign mem_r_en  = ctrl_q.mem_r_en;
  assign mem_w_en  = ctrl_q.mem_w_en;
  assign b         = ctrl_q.b;
  assign s_out     = ctrl_q.s_out;
  assign illegal   = ctrl_q.illegal;
  // Wider command buses are zero-extended from the 4-bit code.
  assign exe_cmd   = EXE_CMD_W'(ctrl_q.exe_cmd);

`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d;
  logic [CNT_W-1:0] cnt_sq_q, cnt_sq_d;

  // Free-running, wrap naturally; flush never coincides with an accept.
  always_comb begin
    cnt_dec_d = cnt_dec_q + CNT_W'(load);
    cnt_sq_d  = cnt_sq_q + CNT_W'(squash);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_dec_q <= '0;
      cnt_sq_q  <= '0;
    end else begin
      cnt_dec_q <= cnt_dec_d;
      cnt_sq_q  <= cnt_sq_d;
    end
  end

  assign cnt_dec = cnt_dec_q;
  assign cnt_sq  = cnt_sq_q;
`endif

endmodule

// File: tb/tb_id_pipe_ctrl.sv
// Purpose: scoreboard bench for id_pipe_ctrl: directed cases plus randomized traffic.
// Latency: expects a decoded word one cycle after accept.
// Backpressure: randomizes out_ready and flush; checks held words and in_ready.
module tb_id_pipe_ctrl;

  localparam int EXE_CMD_W = 6;
  localparam int BR_SHADOW = 2;
  localparam int CNT_W     = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           opcode;
  logic [1:0]           mode;
  logic                 s_in;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic                 wb_en, mem_r_en, mem_w_en, b, s_out, illegal;
  logic [EXE_CMD_W-1:0] exe_cmd;
`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0]     cnt_dec, cnt_sq;
`endif

  id_pipe_ctrl #(
    .EXE_CMD_W (EXE_CMD_W),
    .BR_SHADOW (BR_SHADOW),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .mode      (mode),
    .s_in      (s_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_en     (wb_en),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .b         (b),
    .s_out     (s_out),
    .illegal   (illegal),
    .exe_cmd   (exe_cmd)
`ifdef ID_PERF_CNT_EN
    ,
    .cnt_dec   (cnt_dec),
    .cnt_sq    (cnt_sq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference decode tables, filled straight from the instruction-set listing.
  logic [3:0] rt_cmd [16];
  logic       rt_wb  [16];
  logic       rt_ok  [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      rt_cmd[i] = 4'h0;
      rt_wb[i]  = 1'b0;
      rt_ok[i]  = 1'b0;
    end
    rt_cmd[13] = 4'b0001; rt_wb[13] = 1'b1; rt_ok[13] = 1'b1; // MOV
    rt_cmd[15] = 4'b1001; rt_wb[15] = 1'b1; rt_ok[15] = 1'b1; // MVN
    rt_cmd[4]  = 4'b0010; rt_wb[4]  = 1'b1; rt_ok[4]  = 1'b1; // ADD
    rt_cmd[5]  = 4'b0011; rt_wb[5]  = 1'b1; rt_ok[5]  = 1'b1; // ADC
    rt_cmd[2]  = 4'b0100; rt_wb[2]  = 1'b1; rt_ok[2]  = 1'b1; // SUB
    rt_cmd[6]  = 4'b0101; rt_wb[6]  = 1'b1; rt_ok[6]  = 1'b1; // SBC
    rt_cmd[0]  = 4'b0110; rt_wb[0]  = 1'b1; rt_ok[0]  = 1'b1; // AND
    rt_cmd[12] = 4'b0111; rt_wb[12] = 1'b1; rt_ok[12] = 1'b1; // ORR
    rt_cmd[1]  = 4'b1000; rt_wb[1]  = 1'b1; rt_ok[1]  = 1'b1; // EOR
    rt_cmd[10] = 4'b0100; rt_wb[10] = 1'b0; rt_ok[10] = 1'b1; // CMP
    rt_cmd[8]  = 4'b0110; rt_wb[8]  = 1'b0; rt_ok[8]  = 1'b1; // TST
  end

  // Expected word layout: {wb, mem_r, mem_w, b, s, illegal, cmd[3:0]}.
  function automatic logic [9:0] ref_word(input logic [1:0] m, input logic [3:0] op, input logic s);
    logic [9:0] w;
    w = 10'b0;
    if (m == 2'b00) begin
      if (rt_ok[op]) w = {rt_wb[op], 3'b000, s, 1'b0, rt_cmd[op]};
      else           w = 10'b00_0001_0000;
    end else if (m == 2'b01) begin
      w = s ? {1'b1, 1'b1, 1'b0, 3'b000, 4'b0010} : {1'b0, 1'b0, 1'b1, 3'b000, 4'b0010};
    end else if (m == 2'b10) begin
      w = 10'b00_0100_0000;
    end else begin
      w = 10'b00_0001_0000;
    end
    return w;
  endfunction

  // Model state: pending word queue, occupancy, shadow slots left, counters.
  logic [9:0] exp_q[$];
  bit         model_vld;
  int         shadow_left;
  int         m_dec, m_sq;
  bit         run;
  int         xfer_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_vld   = 1'b0;
      shadow_left = 0;
      m_dec       = 0;
      m_sq        = 0;
    end else if (run) begin
      if (flush) begin
        exp_q.delete();
        model_vld   = 1'b0;
        shadow_left = 0;
      end else begin
        logic acc, ld;
        logic [9:0] w;
        acc = in_valid && (!model_vld || out_ready);
        ld  = 1'b0;
        w   = ref_word(mode, opcode, s_in);
        if (acc && shadow_left > 0) begin
          shadow_left--;
          m_sq++;
        end else if (acc) begin
          ld = 1'b1;
          exp_q.push_back(w);
          m_dec++;
          if (w[6]) shadow_left = BR_SHADOW;
        end
        model_vld = ld || (model_vld && !out_ready);
      end
    end
  end

  // Monitor: samples mid-cycle, pops on each downstream transfer.
  always begin
    @(negedge clk);
    #4;
    if (run && rst_n) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, model_vld});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!model_vld || out_ready) && !flush});
`ifdef ID_PERF_CNT_EN
      chk("cnt_dec", {24'b0, cnt_dec}, {24'b0, CNT_W'(m_dec)});
      chk("cnt_sq", {24'b0, cnt_sq}, {24'b0, CNT_W'(m_sq)});
`endif
      if (out_valid && out_ready && !flush) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("ctrl_word", {20'b0, wb_en, mem_r_en, mem_w_en, b, s_out, illegal, exe_cmd},
              {20'b0, e[9:4], 2'b00, e[3:0]});
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    mode      = m;
    opcode    = op;
    s_in      = s;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({nm, "_ctrl"}, {20'b0, wb_en, mem_r_en, mem_w_en, b, s_out, illegal, exe_cmd}, 32'd0);
`ifdef ID_PERF_CNT_EN
    chk({nm, "_cnt"}, {16'b0, cnt_dec, cnt_sq}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    run       = 1'b0;
    xfer_cnt  = 0;
    in_valid  = 1'b0;
    mode      = 2'b00;
    opcode    = 4'h0;
    s_in      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    chk_all_zero("reset");
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;

    // ADD with S, taken immediately.
    drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Branch shadow: B, MOV, SUB, AND -> only B and AND come out.
    base = xfer_cnt;
    drive(1'b1, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("shadow_outputs", xfer_cnt - base, 32'd2);
`ifdef ID_PERF_CNT_EN
    chk("shadow_cnt_sq", {24'b0, cnt_sq}, 32'd2);
    chk("shadow_cnt_dec", {24'b0, cnt_dec}, 32'd3);
`endif

    // LDR then STR, downstream stalled three cycles.
    drive(1'b1, 2'b01, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0);
    #4;
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_hold_ldr", {30'b0, mem_r_en, mem_w_en}, 32'd2);
    drive(1'b1, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    #4;
    chk("str_after_ready", {30'b0, mem_r_en, mem_w_en}, 32'd1);
    idle(1);

    // Flush while holding a branch in its shadow; next instruction must flow.
    drive(1'b1, 2'b10, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 4'b1101, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    #4;
    chk("flush_clears_valid", {31'b0, out_valid}, 32'd0);
    base = xfer_cnt;
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("post_flush_not_squashed", xfer_cnt - base, 32'd1);

    // Reserved mode and undefined RT opcode.
    drive(1'b1, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 4'b0011, 1'b1, 1'b0, 1'b1);
    #4;
    chk("illegal_rsv", {31'b0, illegal}, 32'd1);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] m;
      r = $urandom_range(0, 9);
      m = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      drive(($urandom_range(0, 3) != 0), m, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
    end
    idle(4);
    chk("drain_empty", exp_q.size(), 32'd0);

    // Asynchronous reset while a word is stalled.
    drive(1'b1, 2'b01, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    #4;
    chk("stall_before_reset", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    drive(1'b1, 2'b00, 4'b1111, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("final_drain_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
